// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one single-port data RAM between ports A and B
module dmem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t        state, state_nx;
    logic [1:0]    lat_cnt;
    logic          last_grant;  // 1 = B was granted last
    logic          owner;       // 1 = B owns the read in flight
    logic [AW-1:0] rd_addr;
    logic          grant_a, grant_b, rd_done;

    // Outputs are gated by rst so grants drop the moment reset asserts,
    // even though the request inputs are still live.
    always_comb begin
        state_nx  = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        rd_done   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        a_rvalid  = 1'b0;
        a_rdata   = '0;
        b_rvalid  = 1'b0;
        b_rdata   = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    grant_a = a_req && (!b_req || last_grant);
                    grant_b = b_req && (!a_req || !last_grant);
                    if (grant_a) begin
                        mem_we    = a_we;
                        mem_addr  = a_addr;
                        mem_wdata = a_wdata;
                        if (!a_we) state_nx = RD_WAIT;
                    end else if (grant_b) begin
                        mem_we    = b_we;
                        mem_addr  = b_addr;
                        mem_wdata = b_wdata;
                        if (!b_we) state_nx = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    mem_addr = rd_addr;
                    if (lat_cnt == LAT) begin
                        rd_done  = 1'b1;
                        state_nx = IDLE;
                        if (owner) begin
                            b_rvalid = 1'b1;
                            b_rdata  = mem_rdata;
                        end else begin
                            a_rvalid = 1'b1;
                            a_rdata  = mem_rdata;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        a_gnt = grant_a;
        b_gnt = grant_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat_cnt    <= 2'd0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            rd_addr    <= '0;
        end else begin
            state <= state_nx;
            if (grant_a || grant_b) begin
                last_grant <= grant_b;
                if (!mem_we) begin
                    lat_cnt <= 2'd1;
                    owner   <= grant_b;
                    rd_addr <= mem_addr;
                end
            end else if (state == RD_WAIT) begin
                lat_cnt <= rd_done ? 2'd0 : lat_cnt + 2'd1;
            end
        end
    end

    a_one_gnt: assert property (@(posedge clk) disable iff (!rst) !(a_gnt && b_gnt));
    a_one_rvalid: assert property (@(posedge clk) disable iff (!rst) !(a_rvalid && b_rvalid));
    a_we_gnt: assert property (@(posedge clk) disable iff (!rst) mem_we |-> (a_gnt || b_gnt));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - random and directed checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         rst_n;
    logic [1:0]         a_req, a_we, a_gnt, a_rvalid;
    logic [1:0]         b_req, b_we, b_gnt, b_rvalid;
    logic [1:0][AW-1:0] a_addr, b_addr, mem_addr;
    logic [1:0][DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [1:0]         mem_we;

    // Instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(g == 0 ? 1 : 3)) dut (
            .clk(clk), .rst(rst_n[g]),
            .a_req(a_req[g]), .a_we(a_we[g]), .a_addr(a_addr[g]), .a_wdata(a_wdata[g]),
            .a_gnt(a_gnt[g]), .a_rvalid(a_rvalid[g]), .a_rdata(a_rdata[g]),
            .b_req(b_req[g]), .b_we(b_we[g]), .b_addr(b_addr[g]), .b_wdata(b_wdata[g]),
            .b_gnt(b_gnt[g]), .b_rvalid(b_rvalid[g]), .b_rdata(b_rdata[g]),
            .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );
    end

    logic [DW-1:0] ram [2][16];
    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            if (mem_we[d]) ram[d][mem_addr[d][3:0]] <= mem_wdata[d];
    always_comb
        for (int d = 0; d < 2; d++) mem_rdata[d] = ram[d][mem_addr[d][3:0]];

    // Reference model: cycle counts and a plain memory image per instance.
    int            cyc [2];
    int            due [2];
    bit            own_m [2];
    logic [AW-1:0] rda_m [2];
    logic [DW-1:0] rdd_m [2];
    bit            last_m [2];
    logic [DW-1:0] mmem [2][16];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic model_reset(input int d);
        due[d]    = -1;
        last_m[d] = 1'b1;
    endtask

    task automatic check_zero(input int d, input string tag);
        check({tag, "_agnt"}, a_gnt[d], 0);
        check({tag, "_bgnt"}, b_gnt[d], 0);
        check({tag, "_we"}, mem_we[d], 0);
        check({tag, "_addr"}, mem_addr[d], 0);
        check({tag, "_wdata"}, mem_wdata[d], 0);
        check({tag, "_arv"}, {a_rvalid[d], a_rdata[d]}, 0);
        check({tag, "_brv"}, {b_rvalid[d], b_rdata[d]}, 0);
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance the model.
    task automatic step(input int d,
                        input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        output bit ea, output bit eb, output bit ga, output bit gb);
        bit            busy, erva, ervb, eme;
        logic [AW-1:0] ema;
        logic [DW-1:0] emd, erda, erdb;
        a_req[d] = ar; a_we[d] = aw; a_addr[d] = aa; a_wdata[d] = ad;
        b_req[d] = br; b_we[d] = bw; b_addr[d] = ba; b_wdata[d] = bd;
        @(negedge clk);
        ea = 0; eb = 0; erva = 0; ervb = 0; eme = 0; ema = '0; emd = '0; erda = '0; erdb = '0;
        busy = (due[d] >= 0);
        if (busy) begin
            ema = rda_m[d];
            if (cyc[d] == due[d]) begin
                if (own_m[d]) begin ervb = 1; erdb = rdd_m[d]; end
                else          begin erva = 1; erda = rdd_m[d]; end
            end
        end else begin
            ea = ar && (!br || last_m[d]);
            eb = br && (!ar || !last_m[d]);
            if (ea) begin eme = aw; ema = aa; emd = ad; end
            if (eb) begin eme = bw; ema = ba; emd = bd; end
        end
        ga = a_gnt[d];
        gb = b_gnt[d];
        check("a_gnt", a_gnt[d], ea);
        check("b_gnt", b_gnt[d], eb);
        check("mem_we", mem_we[d], eme);
        check("mem_addr", mem_addr[d], ema);
        check("mem_wdata", mem_wdata[d], emd);
        check("a_rvalid", a_rvalid[d], erva);
        check("a_rdata", a_rdata[d], erda);
        check("b_rvalid", b_rvalid[d], ervb);
        check("b_rdata", b_rdata[d], erdb);
        if (busy && cyc[d] == due[d]) due[d] = -1;
        if (ea || eb) begin
            last_m[d] = eb;
            if (eme) mmem[d][ema[3:0]] = emd;
            else begin
                due[d]   = cyc[d] + lat(d);
                own_m[d] = eb;
                rda_m[d] = ema;
                rdd_m[d] = mmem[d][ema[3:0]];
            end
        end
        cyc[d]++;
        @(posedge clk);
        #1;
    endtask

    task automatic random_run(input int d, input int n);
        bit pa = 0, pb = 0, wa = 0, wb = 0, ea, eb, ga, gb;
        logic [AW-1:0] xa = '0, xb = '0;
        logic [DW-1:0] da = '0, db = '0;
        int la = 0, lb = 0;
        for (int i = 0; i < n; i++) begin
            if (!pa && $urandom_range(1, 0) == 1) begin
                pa = 1; wa = $urandom_range(1, 0) == 1; xa = AW'($urandom_range(15, 0)); da = $urandom; la = 0;
            end else if (pa && $urandom_range(15, 0) == 0) pa = 0;
            if (!pb && $urandom_range(1, 0) == 1) begin
                pb = 1; wb = $urandom_range(1, 0) == 1; xb = AW'($urandom_range(15, 0)); db = $urandom; lb = 0;
            end else if (pb && $urandom_range(15, 0) == 0) pb = 0;
            step(d, pa, wa, xa, da, pb, wb, xb, db, ea, eb, ga, gb);
            if (pa && ga) check("starve_a", la <= 1, 1);
            if (pb && gb) check("starve_b", lb <= 1, 1);
            if (pa && gb) la++;
            if (pb && ga) lb++;
            if (ea) pa = 0;
            if (eb) pb = 0;
        end
        for (int i = 0; i < 4; i++) step(d, 0, 0, '0, '0, 0, 0, '0, '0, ea, eb, ga, gb);
    endtask

    initial begin
        bit ea, eb, ga, gb;
        logic [AW-1:0] rd_list [3];
        rd_list[0] = 32'h5; rd_list[1] = 32'h3; rd_list[2] = 32'h1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) begin
                ram[d][k]  = '0;
                mmem[d][k] = '0;
            end
            cyc[d] = 0;
            model_reset(d);
        end
        rst_n = 2'b00;
        a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        a_req[0] = 1'b1;
        b_req[0] = 1'b1;
        #1;
        check_zero(0, "rst");
        a_req = '0; b_req = '0;
        rst_n = 2'b11;

        // Single A write, then two back-to-back B writes.
        step(0, 1, 1, 32'h1, 32'hFA32, 0, 0, '0, '0, ea, eb, ga, gb);
        step(0, 0, 0, '0, '0, 1, 1, 32'h5, 32'hEA99, ea, eb, ga, gb);
        step(0, 0, 0, '0, '0, 1, 1, 32'h3, 32'hEA99, ea, eb, ga, gb);
        check("ram5", ram[0][5], 32'hEA99);
        check("ram3", ram[0][3], 32'hEA99);
        check("ram1", ram[0][1], 32'hFA32);

        // A reads 5, 3, 1 with the request held through each wait cycle.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, rd_list[i], '0, 0, 0, '0, '0, ea, eb, ga, gb);
            check("rd_gnt", ga, 1);
            step(0, 1, 0, (i < 2) ? rd_list[i+1] : rd_list[i], '0, 0, 0, '0, '0, ea, eb, ga, gb);
        end
        step(0, 0, 0, '0, '0, 0, 0, '0, '0, ea, eb, ga, gb);

        // Continuous contention on reads: grants must alternate.
        for (int i = 0; i < 8; i++)
            step(0, 1, 0, 32'h1, '0, 1, 0, 32'h3, '0, ea, eb, ga, gb);
        step(0, 0, 0, '0, '0, 0, 0, '0, '0, ea, eb, ga, gb);

        // B read in flight holds off an A write until after b_rvalid.
        step(0, 0, 0, '0, '0, 1, 0, 32'h3, '0, ea, eb, ga, gb);
        step(0, 1, 1, 32'h7, 32'h1234, 0, 0, '0, '0, ea, eb, ga, gb);
        check("wait_gnt", ga, 0);
        step(0, 1, 1, 32'h7, 32'h1234, 0, 0, '0, '0, ea, eb, ga, gb);
        check("after_gnt", ga, 1);
        step(0, 0, 0, '0, '0, 0, 0, '0, '0, ea, eb, ga, gb);
        check("ram7", ram[0][7], 32'h1234);

        random_run(0, 400);

        // Reset during an RD_LAT=3 read on instance 1.
        step(1, 1, 1, 32'h1, 32'hFA32, 0, 0, '0, '0, ea, eb, ga, gb);
        step(1, 1, 0, 32'h1, '0, 0, 0, '0, '0, ea, eb, ga, gb);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0, ea, eb, ga, gb);
        a_req[1] = 1; a_we[1] = 1; a_addr[1] = 32'h2; a_wdata[1] = 32'h55;
        b_req[1] = 1; b_we[1] = 1; b_addr[1] = 32'h4; b_wdata[1] = 32'h66;
        rst_n[1] = 1'b0;
        #1;
        check_zero(1, "mid_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_arv", a_rvalid[1], 0);
            @(posedge clk);
            #1;
        end
        rst_n[1] = 1'b1;
        model_reset(1);
        step(1, 1, 1, 32'h2, 32'h55, 1, 1, 32'h4, 32'h66, ea, eb, ga, gb);
        check("post_rst_tie", ga, 1);
        step(1, 0, 0, '0, '0, 1, 1, 32'h4, 32'h66, ea, eb, ga, gb);

        random_run(1, 400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end
endmodule
